// File: rtl/seg7_decade_display.sv
// Purpose : 4-digit BCD up/down counter stepped by iTICK falling edges, driving a
//           multiplexed active-low 7-segment display with optional leading-zero blanking.
// Latency : oBCD/oCARRY update on the iCLK falling edge that samples the step; oSEG/oAN registered.
// Backpressure: none; steps seen while iEN=0 are dropped, never queued.
//
// Ports:
//   iCLK   - system clock; all state changes on its falling edge
//   iRST   - synchronous active-high reset
//   iTICK  - square-wave time base; each falling edge is one step event
//   iEN    - count enable, sampled in the event cycle
//   iUP    - direction (1 = up, 0 = down), sampled in the event cycle
//   oBCD   - current count {d3,d2,d1,d0}
//   oCARRY - one-cycle pulse while oBCD shows a wrapped value
//   oSEG   - segments {g,f,e,d,c,b,a}, active-low
//   oAN    - digit anodes, one-hot active-low, bit n = digit n
module seg7_decade_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iTICK,
  input  logic        iEN,
  input  logic        iUP,
  output logic [15:0] oBCD,
  output logic        oCARRY,
  output logic [6:0]  oSEG,
  output logic [3:0]  oAN
);

  // A divider of 1 still needs a 1-bit counter so the terminal compare is legal.
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Segment decode for one BCD digit, gfedcba active-low.
  function automatic logic [6:0] decodeDigit(input logic [3:0] dig);
    logic [6:0] seg;
    case (dig)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             rTickD;
  logic [3:0][3:0]  bcdQ;
  logic [REF_W-1:0] refCnt;
  logic [1:0]       sel;

  // ---------------------------------------------------------------------------
  // Step detection
  // ---------------------------------------------------------------------------
  logic stepEvt;
  logic doStep;

  // Falling edge of iTICK relative to the registered copy; rTickD resets to 0 so
  // the first cycle after reset can never look like a fall.
  assign stepEvt = rTickD & ~iTICK;
  assign doStep  = stepEvt & iEN;

  // ---------------------------------------------------------------------------
  // Decade counter next value
  // ---------------------------------------------------------------------------
  logic [3:0][3:0] bcdStep;
  logic            wrapStep;

  // Ripple the carry/borrow from d0 upward. If it leaves d3 the whole count
  // wrapped (9999->0000 or 0000->9999).
  always_comb begin
    logic ripple;
    bcdStep = bcdQ;
    ripple  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ripple) begin
        if (iUP) begin
          if (bcdQ[i] >= 4'd9) begin
            bcdStep[i] = 4'd0;
          end else begin
            bcdStep[i] = bcdQ[i] + 4'd1;
            ripple     = 1'b0;
          end
        end else begin
          if (bcdQ[i] == 4'd0) begin
            bcdStep[i] = 4'd9;
          end else begin
            bcdStep[i] = bcdQ[i] - 4'd1;
            ripple     = 1'b0;
          end
        end
      end
    end
    wrapStep = ripple;
  end

  logic [3:0][3:0] bcdNext;
  logic            carryNext;

  assign bcdNext   = doStep ? bcdStep : bcdQ;
  assign carryNext = doStep & wrapStep;

  // ---------------------------------------------------------------------------
  // Refresh scan next state
  // ---------------------------------------------------------------------------
  logic             refTerm;
  logic [REF_W-1:0] refNext;
  logic [1:0]       selNext;

  always_comb begin
    refTerm = (refCnt == REF_LAST);
    refNext = refTerm ? '0 : refCnt + REF_W'(1);
    selNext = refTerm ? sel + 2'd1 : sel;
  end

  // ---------------------------------------------------------------------------
  // Display outputs next value
  // ---------------------------------------------------------------------------
  // Segments and anodes are both computed from the *next* count and *next*
  // select, so a step and a scan advance in the same cycle land together and
  // the digit shown always matches the anode driven.
  logic [3:0] leadZero;
  logic [3:0] digSel;
  logic [6:0] segNext;
  logic [3:0] anNext;

  always_comb begin
    // leadZero[n] = digit n and every higher digit are zero.
    leadZero[3] = (bcdNext[3] == 4'd0);
    leadZero[2] = leadZero[3] & (bcdNext[2] == 4'd0);
    leadZero[1] = leadZero[2] & (bcdNext[1] == 4'd0);
    leadZero[0] = 1'b0;  // digit 0 always shows

    digSel = bcdNext[selNext];
    if ((BLANK_LZ != 0) && leadZero[selNext]) begin
      segNext = SEG_BLANK;
    end else begin
      segNext = decodeDigit(digSel);
    end

    anNext = ~(4'b0001 << selNext);
  end

  // ---------------------------------------------------------------------------
  // Registers (falling edge of iCLK)
  // ---------------------------------------------------------------------------
  // Reset wins over a coincident step: the event is simply lost.
  always_ff @(negedge iCLK) begin
    if (iRST) begin
      rTickD <= 1'b0;
      bcdQ   <= '0;
      oCARRY <= 1'b0;
      refCnt <= '0;
      sel    <= 2'd0;
      oAN    <= 4'b1110;
      oSEG   <= 7'b1000000;
    end else begin
      rTickD <= iTICK;
      bcdQ   <= bcdNext;
      oCARRY <= carryNext;
      refCnt <= refNext;
      sel    <= selNext;
      oAN    <= anNext;
      oSEG   <= segNext;
    end
  end

  assign oBCD = bcdQ;

endmodule

// File: tb/tb_seg7_decade_display.sv
module tb_seg7_decade_display;

  logic        iCLK;
  logic        iRST;
  logic        iTICK;
  logic        iEN;
  logic        iUP;
  logic [15:0] oBCD;
  logic        oCARRY;
  logic [6:0]  oSEG;
  logic [3:0]  oAN;

  int nChecks = 0;
  int nErrors = 0;

  seg7_decade_display #(
    .REFRESH_DIV(4),
    .BLANK_LZ   (1)
  ) dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iTICK (iTICK),
    .iEN   (iEN),
    .iUP   (iUP),
    .oBCD  (oBCD),
    .oCARRY(oCARRY),
    .oSEG  (oSEG),
    .oAN   (oAN)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // DUT acts on the falling edge; the bench drives and samples on the rising edge.
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full iTICK period: rise, then fall; returns on the rising iCLK edge
  // right after the falling iCLK edge that samples the step.
  task automatic tickStep();
    iTICK = 1'b1;
    @(posedge iCLK);
    iTICK = 1'b0;
    @(posedge iCLK);
  endtask

  logic [3:0] expAn  [4];
  logic [6:0] expSeg [4];
  logic [3:0] prevAn;
  logic       found;

  initial begin
    expAn  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    expSeg = '{7'b0010010, 7'b1000000, 7'b1111001, 7'b1111111};

    iRST  = 1'b1;
    iTICK = 1'b1;
    iEN   = 1'b0;
    iUP   = 1'b1;
    repeat (3) @(posedge iCLK);

    // Reset state
    check("rst_bcd",   oBCD,   16'h0000);
    check("rst_carry", {15'd0, oCARRY}, 16'd0);
    check("rst_an",    {12'd0, oAN},    16'h000E);
    check("rst_seg",   {9'd0, oSEG},    16'h0040);

    // Release with iTICK high: no false step
    iRST = 1'b0;
    iEN  = 1'b1;
    iUP  = 1'b1;
    @(posedge iCLK);
    check("no_false_step", oBCD, 16'h0000);

    // First fall -> 0001
    iTICK = 1'b0;
    @(posedge iCLK);
    check("first_up",       oBCD, 16'h0001);
    check("first_up_carry", {15'd0, oCARRY}, 16'd0);

    // Down through zero
    iUP = 1'b0;
    tickStep();
    check("down_to_0",       oBCD, 16'h0000);
    check("down_to_0_carry", {15'd0, oCARRY}, 16'd0);
    tickStep();
    check("down_wrap",       oBCD, 16'h9999);
    check("down_wrap_carry", {15'd0, oCARRY}, 16'd1);
    @(posedge iCLK);
    check("down_wrap_carry_end", {15'd0, oCARRY}, 16'd0);
    check("down_wrap_hold",      oBCD, 16'h9999);

    // Up through 9999
    iUP = 1'b1;
    tickStep();
    check("up_wrap",       oBCD, 16'h0000);
    check("up_wrap_carry", {15'd0, oCARRY}, 16'd1);
    @(posedge iCLK);
    check("up_wrap_carry_end", {15'd0, oCARRY}, 16'd0);

    // Multi-digit carry 0099 -> 0100
    repeat (99) tickStep();
    check("count_99", oBCD, 16'h0099);
    tickStep();
    check("carry_chain",       oBCD, 16'h0100);
    check("carry_chain_carry", {15'd0, oCARRY}, 16'd0);

    // Borrow chain 1000 -> 0999
    repeat (900) tickStep();
    check("count_1000", oBCD, 16'h1000);
    iUP = 1'b0;
    tickStep();
    check("borrow_chain", oBCD, 16'h0999);

    // Disabled events are discarded
    iEN = 1'b0;
    repeat (5) tickStep();
    check("en_off_hold",  oBCD, 16'h0999);
    check("en_off_carry", {15'd0, oCARRY}, 16'd0);

    // Rising edge alone never steps
    iEN   = 1'b1;
    iUP   = 1'b1;
    iTICK = 1'b1;
    @(posedge iCLK);
    @(posedge iCLK);
    check("rise_no_step", oBCD, 16'h0999);
    iTICK = 1'b0;
    @(posedge iCLK);
    check("fall_steps", oBCD, 16'h1000);

    // iUP only matters in the event cycle
    iUP   = 1'b0;
    iTICK = 1'b1;
    @(posedge iCLK);
    iUP   = 1'b1;
    iTICK = 1'b0;
    @(posedge iCLK);
    check("dir_sampled_at_event", oBCD, 16'h1001);

    // Reset overrides a coincident step at 0042
    iRST = 1'b1;
    @(posedge iCLK);
    iRST = 1'b0;
    repeat (42) tickStep();
    check("count_42", oBCD, 16'h0042);
    iTICK = 1'b1;
    @(posedge iCLK);
    iTICK = 1'b0;
    iRST  = 1'b1;
    @(posedge iCLK);
    check("rst_ovr_bcd",   oBCD, 16'h0000);
    check("rst_ovr_an",    {12'd0, oAN},    16'h000E);
    check("rst_ovr_seg",   {9'd0, oSEG},    16'h0040);
    check("rst_ovr_carry", {15'd0, oCARRY}, 16'd0);
    iRST = 1'b0;

    // Display scan of 0105 with leading-zero blanking
    repeat (105) tickStep();
    check("count_105", oBCD, 16'h0105);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      prevAn = oAN;
      @(posedge iCLK);
      if (prevAn == 4'b0111 && oAN == 4'b1110) found = 1'b1;
    end
    check("scan_sync", {15'd0, found}, 16'd1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("scan_an_%0d", k),  {12'd0, oAN},  {12'd0, expAn[k/4]});
      check($sformatf("scan_seg_%0d", k), {9'd0, oSEG},  {9'd0, expSeg[k/4]});
      @(posedge iCLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/seg7_decade_display.md
SEG7_DECADE_DISPLAY -- requirements
Module: seg7_decade_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning iCLK cycles per displayed digit (1 kHz digit rate at 50 MHz).
REQ-002 SHALL have parameter BLANK_LZ, default 1, meaning 1 = blank leading zeros on digits 3..1.
REQ-003 SHALL have port iCLK  input  1  system clock (50 MHz); all state updates on its negative edge.
REQ-004 SHALL have port iRST  input  1  reset, synchronous to iCLK, active-high.
REQ-005 SHALL have port iTICK  input  1  square-wave time base from the upstream divider (e.g. 4 Hz), same clock domain.
REQ-006 SHALL have port iEN  input  1  count enable; 1 = edges on iTICK advance the count.
REQ-007 SHALL have port iUP  input  1  direction; 1 = up, 0 = down.
REQ-008 SHALL have port oBCD  output  16  current count, 4 BCD digits, {d3,d2,d1,d0}.
REQ-009 SHALL have port oCARRY  output  1  one-cycle pulse on wrap (9999->0000 up, 0000->9999 down).
REQ-010 SHALL have port oSEG  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port oAN  output  4  digit anode select, one-hot active-low, bit n = digit n.

Function
REQ-012 SHALL register iTICK into rTICK_D each cycle; a step event is rTICK_D==1 && iTICK==0 (falling edge), i.e. one step per iTICK period.
REQ-013 SHALL apply a step only when iEN==1 in the event cycle; events with iEN==0 are discarded, not queued.
REQ-014 Up step SHALL increment d0; a digit at 9 becomes 0 and carries into the next digit; digits never hold values 10..15.
REQ-015 Down step SHALL decrement d0; a digit at 0 becomes 9 and borrows from the next digit.
REQ-016 oBCD SHALL update in the same cycle edge that samples the step event (1-cycle latency from iTICK falling).
REQ-017 oCARRY SHALL be 1 for exactly the cycle in which oBCD shows the wrapped value (0000 after up wrap, 9999 after down wrap), else 0.
REQ-018 iUP SHALL be sampled only in the event cycle; a direction change between events takes effect on the next event.
REQ-019 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count digit select advances 0->1->2->3->0.
REQ-020 oAN SHALL be 1110, 1101, 1011, 0111 for select 0, 1, 2, 3; exactly one bit low at all times.
REQ-021 oSEG SHALL be registered from the selected digit and change in the same cycle as oAN, so segments and anode never mismatch.
REQ-022 Decode (gfedcba, active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-023 With BLANK_LZ=1, digit n (n>=1) SHALL show 1111111 when it and all higher digits are 0; digit 0 is never blanked.
REQ-024 A count step and a refresh advance in the same cycle SHALL both take effect; oSEG then reflects the new count for the new select.

Reset
REQ-025 On iRST==1 at a clock edge: oBCD=0000, oCARRY=0, rTICK_D=0, refresh counter=0, select=0, oAN=1110, oSEG=1000000.
REQ-026 iRST SHALL override a step event in the same cycle; the event is lost.
REQ-027 rTICK_D reset to 0 SHALL ensure no false step on the first cycle after reset whatever the level of iTICK.

Verification
REQ-028 Reset with iTICK=1, release, drive iTICK 1->0 with iEN=1, iUP=1 -> oBCD=0001 one cycle after the fall, oCARRY=0.
REQ-029 Count up to 9999, one more falling edge -> oBCD=0000, oCARRY=1 for exactly one cycle; 0099 -> 0100 checks multi-digit carry.
REQ-030 From 0000 with iUP=0, one falling edge -> oBCD=9999, oCARRY=1 for one cycle; 1000 -> 0999 checks borrow chain.
REQ-031 iEN=0 across 5 falling edges -> oBCD unchanged; rising edges of iTICK never change oBCD.
REQ-032 REFRESH_DIV=4, count 0105, BLANK_LZ=1 -> oAN 1110/1101/1011/0111 each for 4 cycles; oSEG 0010010, 1000000, 1111001, 1111111.
REQ-033 Assert iRST in the same cycle as a falling edge at count 0042 -> next cycle oBCD=0000, oAN=1110, oSEG=1000000, oCARRY=0.
